// File: rtl/l0id_tracker_if.sv
// L0ID tracker bus: control inputs and per-channel results.
// The master drives controls; the slave (tracker) drives results.
interface l0id_tracker_if #(
    parameter int ID_WIDTH = 8,
    parameter int NCHAN    = 2
);
    logic                      L0IDReset;
    logic                      L0IDPreset;
    logic [ID_WIDTH-1:0]       PreL0ID;
    logic [NCHAN-1:0]          ROReadStrob;
    logic                      L0IDCheck;
    logic [ID_WIDTH-1:0]       L0IDRef;
    logic                      ClearErr;
    logic [NCHAN*ID_WIDTH-1:0] L0ID_Local;
    logic [NCHAN-1:0]          ROStretch;
    logic [NCHAN-1:0]          Wrap;
    logic [NCHAN-1:0]          Mismatch;

    modport master (
        output L0IDReset, L0IDPreset, PreL0ID,
        output ROReadStrob, L0IDCheck, L0IDRef, ClearErr,
        input  L0ID_Local, ROStretch, Wrap, Mismatch
    );

    modport slave (
        input  L0IDReset, L0IDPreset, PreL0ID,
        input  ROReadStrob, L0IDCheck, L0IDRef, ClearErr,
        output L0ID_Local, ROStretch, Wrap, Mismatch
    );
endinterface

// File: rtl/l0id_tracker.sv
// Per-channel L0ID counters with delayed strobe increment,
// stretched readout flag, wrap pulse and sticky compare error.
module l0id_tracker #(
    parameter int ID_WIDTH  = 8,
    parameter int NCHAN     = 2,
    parameter int INC_DELAY = 1,
    parameter int STRETCH   = 3
) (
    input logic           CLK,
    input logic           SoftReset,
    l0id_tracker_if.slave bus
);
    // Shift register long enough for both the increment tap and
    // the stretch window.
    localparam int SR_LEN =
        (INC_DELAY > STRETCH + 1) ? INC_DELAY : STRETCH + 1;

    typedef logic [ID_WIDTH-1:0] id_t;
    typedef logic [SR_LEN-1:0]   sr_t;

    id_t              cnt_q [NCHAN];
    id_t              cnt_d [NCHAN];
    sr_t              sr_q  [NCHAN];
    sr_t              sr_d  [NCHAN];
    logic [NCHAN-1:0] stretch_q, stretch_d;
    logic [NCHAN-1:0] wrap_q, wrap_d;
    logic [NCHAN-1:0] mism_q, mism_d;
    id_t              load_val;

    assign load_val = bus.L0IDPreset ? bus.PreL0ID : {ID_WIDTH{1'b1}};

    // Next-state for every channel; a load beats a due increment.
    always_comb begin
        stretch_d = '0;
        wrap_d    = '0;
        mism_d    = mism_q;
        for (int c = 0; c < NCHAN; c++) begin
            logic inc;
            sr_d[c]  = {sr_q[c][SR_LEN-2:0], bus.ROReadStrob[c]};
            cnt_d[c] = cnt_q[c];
            inc      = sr_q[c][INC_DELAY-1];
            stretch_d[c] = |sr_q[c][STRETCH:1];
            if (bus.L0IDReset) begin
                cnt_d[c] = load_val;
            end else if (inc) begin
                cnt_d[c]  = cnt_q[c] + 1'b1;
                wrap_d[c] = &cnt_q[c];
            end
            if (bus.L0IDCheck && (cnt_q[c] != bus.L0IDRef)) begin
                mism_d[c] = 1'b1;
            end else if (bus.ClearErr) begin
                mism_d[c] = 1'b0;
            end
        end
    end

    // State registers; SoftReset clears in-flight strobes too.
    always_ff @(posedge CLK or posedge SoftReset) begin
        if (SoftReset) begin
            for (int c = 0; c < NCHAN; c++) begin
                cnt_q[c] <= {ID_WIDTH{1'b1}};
                sr_q[c]  <= '0;
            end
            stretch_q <= '0;
            wrap_q    <= '0;
            mism_q    <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                cnt_q[c] <= cnt_d[c];
                sr_q[c]  <= sr_d[c];
            end
            stretch_q <= stretch_d;
            wrap_q    <= wrap_d;
            mism_q    <= mism_d;
        end
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_out
        assign bus.L0ID_Local[c*ID_WIDTH +: ID_WIDTH] = cnt_q[c];
    end

    assign bus.ROStretch = stretch_q;
    assign bus.Wrap      = wrap_q;
    assign bus.Mismatch  = mism_q;
endmodule

// File: doc/l0id_tracker.md
L0ID_TRACKER -- requirements
Module: l0id_tracker

Interface
REQ-001 Parameter ID_WIDTH, default 8: width of each local L0ID counter and of PreL0ID/L0IDRef; legal 4..16.
REQ-002 Parameter NCHAN, default 2: number of independent readout channels; legal 1..8.
REQ-003 Parameter INC_DELAY, default 1: cycles from a sampled strobe to the counter update; legal 1..4.
REQ-004 Parameter STRETCH, default 3: length of the stretched readout flag, in cycles; legal 1..8.
REQ-005 CLK  in  1  single block clock; all state updates on its rising edge.
REQ-006 SoftReset  in  1  asynchronous, active-high reset of all state.
REQ-007 L0IDReset  in  1  synchronous load of every channel counter.
REQ-008 L0IDPreset  in  1  load-value select during L0IDReset: 1 = PreL0ID, 0 = all-ones.
REQ-009 PreL0ID  in  ID_WIDTH  preset value.
REQ-010 ROReadStrob  in  NCHAN  per-channel readout strobe; bit c is channel c.
REQ-011 L0IDCheck  in  1  compare-enable for all channels.
REQ-012 L0IDRef  in  ID_WIDTH  reference L0ID for the compare.
REQ-013 ClearErr  in  1  synchronous clear of the mismatch flags.
REQ-014 L0ID_Local  out  NCHAN*ID_WIDTH  counters; channel c occupies bits [c*ID_WIDTH +: ID_WIDTH].
REQ-015 ROStretch  out  NCHAN  registered, stretched readout flag per channel.
REQ-016 Wrap  out  NCHAN  one-cycle pulse when a counter wraps from all-ones to 0.
REQ-017 Mismatch  out  NCHAN  sticky compare-error flag per channel.

Function
REQ-018 Each channel SHALL hold a strobe shift register of max(INC_DELAY, STRETCH+1) bits; bit 0 samples ROReadStrob[c] on each edge, and bit i copies bit i-1.
REQ-019 For a strobe sampled at edge k, the counter of channel c SHALL increment by 1, modulo 2^ID_WIDTH, on edge k+INC_DELAY (INC_DELAY=1: change visible after edge k+1).
REQ-020 Strobes on consecutive cycles SHALL each produce one increment; no strobe SHALL be dropped or merged.
REQ-021 ROStretch[c] SHALL be registered as the OR of shift-register bits [STRETCH:1].
  - Single strobe sampled at edge k: ROStretch[c] is high from edge k+2 through edge k+1+STRETCH.
  - A retrigger SHALL extend the high period.
REQ-022 An increment from all-ones SHALL give 0, and Wrap[c] SHALL be high for exactly the cycle following that edge.
REQ-023 When L0IDReset=1 at an edge, every counter SHALL load (L0IDPreset ? PreL0ID : all-ones).
  - The load SHALL take priority over a coincident increment; that increment is lost.
  - A load SHALL NOT assert Wrap.
  - A load SHALL NOT clear the strobe shift registers, so increments already in flight apply on later edges.
REQ-024 When L0IDCheck=1 at an edge, each channel whose current L0ID_Local differs from L0IDRef SHALL set Mismatch[c] after that edge; the compare uses the pre-edge counter value.
REQ-025 Mismatch[c] SHALL stay set until ClearErr=1 at an edge; a set and a ClearErr on the same edge SHALL leave the flag set.
REQ-026 Channels SHALL be fully independent except for the shared L0IDReset, L0IDCheck and ClearErr.
REQ-027 All outputs SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-028 While SoftReset=1, asynchronously:
  - every counter = all-ones (8'hFF at default width);
  - strobe shift registers = 0;
  - ROStretch = 0, Wrap = 0, Mismatch = 0.
REQ-029 Deassertion of SoftReset SHALL be synchronised externally; the first edge after deassertion behaves as normal operation.
REQ-030 SoftReset asserted mid-operation SHALL discard in-flight strobes, with no increment after release.

Verification (defaults unless stated)
REQ-031 Reset, then ROReadStrob=01 for one cycle at edge k:
  - ch0 = 8'h00 after edge k+1, with Wrap[0] high that cycle;
  - ROStretch[0] high for edges k+2..k+4;
  - ch1 stays 8'hFF.
REQ-032 L0IDReset=1, L0IDPreset=1, PreL0ID=8'h3C, then 5 consecutive strobes on ch1 -> ch1 = 8'h41 and ch0 = 8'h3C.
REQ-033 L0IDReset coincident with a due increment on ch0 (preset 8'h10) -> ch0 = 8'h10 and Wrap stays 0.
REQ-034 ch0 = 8'h05, ch1 = 8'h06, L0IDCheck=1 with L0IDRef=8'h05 -> Mismatch = 10.
  - ClearErr coincident with a new mismatch keeps the flag at 1.
  - ClearErr alone clears it.
REQ-035 INC_DELAY=4, ID_WIDTH=12, NCHAN=4: strobe on ch3 at edge k -> ch3 increments after edge k+4, 12'hFFF to 12'h000 with Wrap[3].
REQ-036 SoftReset asserted between a strobe and its increment -> the counter returns to all-ones with no later increment and all flags 0.
